// File: rtl/bus_arbiter_if.sv
// Bundle of the two CPU-side Wishbone ports and the shared slave port.
// The arbiter connects through "slave"; the surrounding system connects through "master".
interface bus_arbiter_if #(
  parameter int AWIDTH = 32
);
  logic              ins_cyc_i;
  logic              ins_stb_i;
  logic [AWIDTH-1:0] ins_adr_i;
  logic [31:0]       ins_dat_o;
  logic              ins_ack_o;
  logic              ins_err_o;

  logic              dat_cyc_i;
  logic              dat_stb_i;
  logic              dat_we_i;
  logic [3:0]        dat_sel_i;
  logic [AWIDTH-1:0] dat_adr_i;
  logic [31:0]       dat_dat_i;
  logic [31:0]       dat_dat_o;
  logic              dat_ack_o;
  logic              dat_err_o;

  logic              s_cyc_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [3:0]        s_sel_o;
  logic [AWIDTH-1:0] s_adr_o;
  logic [31:0]       s_dat_o;
  logic [31:0]       s_dat_i;
  logic              s_ack_i;

  modport slave (
    input  ins_cyc_i, ins_stb_i, ins_adr_i,
    output ins_dat_o, ins_ack_o, ins_err_o,
    input  dat_cyc_i, dat_stb_i, dat_we_i, dat_sel_i, dat_adr_i, dat_dat_i,
    output dat_dat_o, dat_ack_o, dat_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output ins_cyc_i, ins_stb_i, ins_adr_i,
    input  ins_dat_o, ins_ack_o, ins_err_o,
    output dat_cyc_i, dat_stb_i, dat_we_i, dat_sel_i, dat_adr_i, dat_dat_i,
    input  dat_dat_o, dat_ack_o, dat_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master (fetch, data) to one-slave classic Wishbone arbiter with data priority,
// fetch anti-starvation counter and a no-ack watchdog.
module bus_arbiter #(
  parameter int AWIDTH   = 32,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  bus_arbiter_if.slave bus,
  output logic [1:0]   grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_INS = 2'd1,
    GNT_DAT = 2'd2
  } state_e;

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);
  localparam logic [7:0] TIMEOUT_L  = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] ins_wait_q, ins_wait_d;
  logic [7:0] wd_q, wd_d;

  logic owner_cyc_s;
  logic owner_stb_s;
  logic wd_hit_s;
  logic ack_s;
  logic err_s;

  // State register and counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ins_wait_q <= 4'd0;
      wd_q       <= 8'd0;
    end else begin
      state_q    <= state_d;
      ins_wait_q <= ins_wait_d;
      wd_q       <= wd_d;
    end
  end

  // Current owner's request lines
  always_comb begin
    owner_cyc_s = 1'b0;
    owner_stb_s = 1'b0;
    case (state_q)
      GNT_INS: begin
        owner_cyc_s = bus.ins_cyc_i;
        owner_stb_s = bus.ins_stb_i;
      end
      GNT_DAT: begin
        owner_cyc_s = bus.dat_cyc_i;
        owner_stb_s = bus.dat_stb_i;
      end
      default: begin
        owner_cyc_s = 1'b0;
        owner_stb_s = 1'b0;
      end
    endcase
  end

  // An ack in the timeout cycle takes precedence over the error; nothing reaches a master during reset.
  assign wd_hit_s = (state_q != IDLE) && (wd_q >= TIMEOUT_L);
  assign ack_s    = owner_cyc_s && bus.s_ack_i && !rst_i;
  assign err_s    = owner_cyc_s && wd_hit_s && !bus.s_ack_i && !rst_i;
  assign grant    = state_q;

  // Next-state, starvation counter and watchdog
  always_comb begin
    state_d    = state_q;
    ins_wait_d = ins_wait_q;
    wd_d       = wd_q;
    case (state_q)
      IDLE: begin
        wd_d = 8'd0;
        if (bus.dat_cyc_i && (!bus.ins_cyc_i || (ins_wait_q < MAX_WAIT_L))) begin
          state_d = GNT_DAT;
          if (bus.ins_cyc_i) begin
            ins_wait_d = (ins_wait_q == 4'hF) ? 4'hF : (ins_wait_q + 4'd1);
          end else begin
            ins_wait_d = 4'd0;
          end
        end else if (bus.ins_cyc_i) begin
          state_d    = GNT_INS;
          ins_wait_d = 4'd0;
        end else begin
          state_d    = IDLE;
          ins_wait_d = 4'd0;
        end
      end
      GNT_INS, GNT_DAT: begin
        // Ack, timeout or a dropped cyc all release the slave, leaving one dead IDLE cycle.
        if (!owner_cyc_s || bus.s_ack_i || wd_hit_s) begin
          state_d = IDLE;
          wd_d    = 8'd0;
        end else if (owner_stb_s) begin
          state_d = state_q;
          wd_d    = wd_q + 8'd1;
        end else begin
          state_d = state_q;
          wd_d    = wd_q;
        end
      end
      default: begin
        state_d    = IDLE;
        ins_wait_d = 4'd0;
        wd_d       = 8'd0;
      end
    endcase
  end

  // Slave-side muxing and response routing
  always_comb begin
    bus.s_cyc_o   = 1'b0;
    bus.s_stb_o   = 1'b0;
    bus.s_we_o    = 1'b0;
    bus.s_sel_o   = 4'h0;
    bus.s_adr_o   = {AWIDTH{1'b0}};
    bus.s_dat_o   = 32'h0;
    bus.ins_dat_o = 32'h0;
    bus.ins_ack_o = 1'b0;
    bus.ins_err_o = 1'b0;
    bus.dat_dat_o = 32'h0;
    bus.dat_ack_o = 1'b0;
    bus.dat_err_o = 1'b0;
    case (state_q)
      GNT_INS: begin
        bus.s_cyc_o   = bus.ins_cyc_i && !wd_hit_s;
        bus.s_stb_o   = bus.ins_stb_i && !wd_hit_s;
        bus.s_sel_o   = 4'hF;
        bus.s_adr_o   = bus.ins_adr_i;
        bus.ins_dat_o = bus.s_dat_i;
        bus.ins_ack_o = ack_s;
        bus.ins_err_o = err_s;
      end
      GNT_DAT: begin
        bus.s_cyc_o   = bus.dat_cyc_i && !wd_hit_s;
        bus.s_stb_o   = bus.dat_stb_i && !wd_hit_s;
        bus.s_we_o    = bus.dat_we_i;
        bus.s_sel_o   = bus.dat_sel_i;
        bus.s_adr_o   = bus.dat_adr_i;
        bus.s_dat_o   = bus.dat_dat_i;
        bus.dat_dat_o = bus.s_dat_i;
        bus.dat_ack_o = ack_s;
        bus.dat_err_o = err_s;
      end
      default: begin
        bus.s_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: fetch-only, priority/starvation, data write,
// watchdog timeout, ack-vs-timeout race and reset mid-transfer.
module tb_bus_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] grant;
  int         n_checks = 0;
  int         n_errors = 0;

  // slave_mode: 0 zero-wait, 1 one wait state, 2 never ack, 3 manual ack
  int         slave_mode = 1;
  logic       manual_ack = 1'b0;
  logic       ack_reg = 1'b0;

  bus_arbiter_if #(.AWIDTH(32)) bus ();

  bus_arbiter #(.AWIDTH(32), .MAX_WAIT(4), .TIMEOUT(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus),
    .grant (grant)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    ack_reg <= (slave_mode == 1) && bus.s_cyc_o && bus.s_stb_o && !ack_reg;
  end

  assign bus.s_ack_i = (slave_mode == 0) ? (bus.s_cyc_o & bus.s_stb_o) :
                       (slave_mode == 1) ? ack_reg :
                       (slave_mode == 3) ? manual_ack : 1'b0;
  assign bus.s_dat_i = {16'hC0DE, bus.s_adr_o[15:0]};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_masters();
    bus.ins_cyc_i = 1'b0;
    bus.ins_stb_i = 1'b0;
    bus.ins_adr_i = 32'h0;
    bus.dat_cyc_i = 1'b0;
    bus.dat_stb_i = 1'b0;
    bus.dat_we_i  = 1'b0;
    bus.dat_sel_i = 4'h0;
    bus.dat_adr_i = 32'h0;
    bus.dat_dat_i = 32'h0;
  endtask

  logic [31:0] fetch_adr [3];
  logic [31:0] fetch_exp [3];
  logic [1:0]  prio_exp  [6];

  initial begin
    fetch_adr[0] = 32'h100; fetch_adr[1] = 32'h104; fetch_adr[2] = 32'h108;
    fetch_exp[0] = 32'hC0DE0100; fetch_exp[1] = 32'hC0DE0104; fetch_exp[2] = 32'hC0DE0108;
    prio_exp[0] = 2'd2; prio_exp[1] = 2'd2; prio_exp[2] = 2'd2;
    prio_exp[3] = 2'd2; prio_exp[4] = 2'd1; prio_exp[5] = 2'd2;

    clear_masters();
    tick();
    tick();
    check_eq("rst_grant", grant, 2'd0);
    check_eq("rst_s_cyc", bus.s_cyc_o, 1'b0);
    check_eq("rst_s_stb", bus.s_stb_o, 1'b0);
    check_eq("rst_ins_ack", bus.ins_ack_o, 1'b0);
    check_eq("rst_dat_err", bus.dat_err_o, 1'b0);
    rst_i = 1'b0;
    tick();

    // Fetch only, one wait state: grant, ack, dead cycle per transfer
    slave_mode = 1;
    bus.ins_cyc_i = 1'b1;
    bus.ins_stb_i = 1'b1;
    bus.ins_adr_i = fetch_adr[0];
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("f_grant", grant, 2'd1);
      check_eq("f_s_adr", bus.s_adr_o, fetch_adr[k]);
      check_eq("f_s_sel", bus.s_sel_o, 4'hF);
      check_eq("f_wait_ack", bus.ins_ack_o, 1'b0);
      tick();
      check_eq("f_ack", bus.ins_ack_o, 1'b1);
      check_eq("f_data", bus.ins_dat_o, fetch_exp[k]);
      check_eq("f_dat_ack", bus.dat_ack_o, 1'b0);
      tick();
      check_eq("f_idle_grant", grant, 2'd0);
      check_eq("f_idle_ack", bus.ins_ack_o, 1'b0);
      if (k < 2) begin
        bus.ins_adr_i = fetch_adr[k+1];
      end else begin
        clear_masters();
      end
    end

    // Both request, zero-wait slave: D,D,D,D,I,D
    slave_mode = 0;
    bus.ins_cyc_i = 1'b1;
    bus.ins_stb_i = 1'b1;
    bus.ins_adr_i = 32'h200;
    bus.dat_cyc_i = 1'b1;
    bus.dat_stb_i = 1'b1;
    bus.dat_adr_i = 32'h1000;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("p_grant", grant, prio_exp[i]);
      check_eq("p_ins_ack", bus.ins_ack_o, prio_exp[i] == 2'd1);
      check_eq("p_dat_ack", bus.dat_ack_o, prio_exp[i] == 2'd2);
      tick();
      check_eq("p_idle", grant, 2'd0);
    end
    clear_masters();

    // Data write
    slave_mode = 1;
    bus.dat_cyc_i = 1'b1;
    bus.dat_stb_i = 1'b1;
    bus.dat_we_i  = 1'b1;
    bus.dat_sel_i = 4'b0011;
    bus.dat_adr_i = 32'h2000;
    bus.dat_dat_i = 32'hDEADBEEF;
    tick();
    check_eq("w_grant", grant, 2'd2);
    check_eq("w_s_we", bus.s_we_o, 1'b1);
    check_eq("w_s_sel", bus.s_sel_o, 4'h3);
    check_eq("w_s_dat", bus.s_dat_o, 32'hDEADBEEF);
    check_eq("w_s_adr", bus.s_adr_o, 32'h2000);
    tick();
    check_eq("w_dat_ack", bus.dat_ack_o, 1'b1);
    check_eq("w_ins_ack", bus.ins_ack_o, 1'b0);
    check_eq("w_ins_dat", bus.ins_dat_o, 32'h0);
    clear_masters();
    tick();
    check_eq("w_idle", grant, 2'd0);

    // Watchdog: data never acked, fetch pending
    slave_mode = 2;
    bus.dat_cyc_i = 1'b1;
    bus.dat_stb_i = 1'b1;
    bus.dat_adr_i = 32'h3000;
    bus.ins_cyc_i = 1'b1;
    bus.ins_stb_i = 1'b1;
    bus.ins_adr_i = 32'h300;
    tick();
    check_eq("t_grant", grant, 2'd2);
    check_eq("t_s_stb", bus.s_stb_o, 1'b1);
    for (int c = 1; c < 8; c++) begin
      tick();
      check_eq("t_early_err", bus.dat_err_o, 1'b0);
    end
    tick();
    check_eq("t_err", bus.dat_err_o, 1'b1);
    check_eq("t_s_cyc", bus.s_cyc_o, 1'b0);
    check_eq("t_s_stb_low", bus.s_stb_o, 1'b0);
    check_eq("t_ins_err", bus.ins_err_o, 1'b0);
    bus.dat_cyc_i = 1'b0;
    bus.dat_stb_i = 1'b0;
    tick();
    check_eq("t_idle", grant, 2'd0);
    check_eq("t_err_once", bus.dat_err_o, 1'b0);
    slave_mode = 1;
    tick();
    check_eq("t_fetch_grant", grant, 2'd1);
    tick();
    check_eq("t_fetch_ack", bus.ins_ack_o, 1'b1);
    clear_masters();
    tick();

    // Ack in the same cycle the watchdog expires
    slave_mode = 3;
    manual_ack = 1'b0;
    bus.dat_cyc_i = 1'b1;
    bus.dat_stb_i = 1'b1;
    bus.dat_adr_i = 32'h4000;
    tick();
    for (int c = 1; c < 8; c++) begin
      tick();
    end
    tick();
    manual_ack = 1'b1;
    #1;
    check_eq("r_ack", bus.dat_ack_o, 1'b1);
    check_eq("r_err", bus.dat_err_o, 1'b0);
    clear_masters();
    manual_ack = 1'b0;
    tick();
    check_eq("r_idle", grant, 2'd0);

    // Reset while fetch is waiting for an ack
    bus.ins_cyc_i = 1'b1;
    bus.ins_stb_i = 1'b1;
    bus.ins_adr_i = 32'h500;
    tick();
    check_eq("x_grant", grant, 2'd1);
    tick();
    tick();
    rst_i = 1'b1;
    manual_ack = 1'b1;
    #1;
    check_eq("x_rst_ack", bus.ins_ack_o, 1'b0);
    check_eq("x_rst_err", bus.ins_err_o, 1'b0);
    tick();
    check_eq("x_grant0", grant, 2'd0);
    check_eq("x_s_cyc", bus.s_cyc_o, 1'b0);
    check_eq("x_s_stb", bus.s_stb_o, 1'b0);
    check_eq("x_s_adr", bus.s_adr_o, 32'h0);
    check_eq("x_ins_ack", bus.ins_ack_o, 1'b0);
    rst_i = 1'b0;
    #1;
    check_eq("x_idle_ack", bus.ins_ack_o, 1'b0);
    manual_ack = 1'b0;
    slave_mode = 0;
    bus.dat_cyc_i = 1'b1;
    bus.dat_stb_i = 1'b1;
    bus.dat_adr_i = 32'h6000;
    tick();
    check_eq("x_resume_grant", grant, 2'd2);
    check_eq("x_resume_ack", bus.dat_ack_o, 1'b1);
    check_eq("x_resume_data", bus.dat_dat_o, 32'hC0DE6000);
    clear_masters();
    tick();
    check_eq("x_end_idle", grant, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
